// File: rtl/multi_edge_detect_pkg.sv
// Shared constants, counter-width helper and edge classification for multi_edge_detect.
// Optional idle-timeout feature is enabled by defining MULTI_EDGE_DETECT_TIMEOUT_EN.
package multi_edge_detect_pkg;

    localparam int   DEFAULT_SYNC_STAGES    = 2;
    localparam int   DEFAULT_FILTER_LEN     = 4;
    localparam logic PS2_IDLE_LEVEL         = 1'b1;
    localparam int   DEFAULT_TIMEOUT_CYCLES = 50000;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_kind_t;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/multi_edge_detect_chan.sv
// One channel: synchroniser, stability filter, registered edge strobes and,
// with MULTI_EDGE_DETECT_TIMEOUT_EN defined, a saturating idle-timeout counter.
module multi_edge_detect_chan
    import multi_edge_detect_pkg::*;
#(
    parameter int   SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int   FILTER_LEN     = DEFAULT_FILTER_LEN,
    parameter logic RESET_LEVEL    = PS2_IDLE_LEVEL,
    parameter int   TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rising_edge,
    output logic falling_edge,
    output logic timeout
);

    localparam int                CNT_W   = cnt_width(FILTER_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_s;
    logic                   level_q;
    logic                   level_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    edge_kind_t             edge_kind;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    assign sync_s = sync_q[SYNC_STAGES-1];

    // Any sample agreeing with the current level wipes the accumulated count.
    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        edge_kind = EDGE_NONE;
        if (sync_s != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d   = sync_s;
                edge_kind = sync_s ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign rise_d = (edge_kind == EDGE_RISE);
    assign fall_d = (edge_kind == EDGE_FALL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level        = level_q;
    assign rising_edge  = rise_q;
    assign falling_edge = fall_q;

`ifdef MULTI_EDGE_DETECT_TIMEOUT_EN
    localparam int               IDLE_W   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;

    // Cleared on the same edge that registers a strobe, so the flag drops with it.
    always_comb begin
        idle_d = idle_q;
        if (rise_d || fall_d) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign timeout = (idle_q == IDLE_MAX);
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel glitch-filtered edge detector for PS/2 lines and pushbuttons.
// Define MULTI_EDGE_DETECT_TIMEOUT_EN to enable the per-channel idle timeout.
module multi_edge_detect
    import multi_edge_detect_pkg::*;
#(
    parameter int   CHANNELS       = 2,
    parameter int   SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int   FILTER_LEN     = DEFAULT_FILTER_LEN,
    parameter logic RESET_LEVEL    = PS2_IDLE_LEVEL,
    parameter int   TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [CHANNELS-1:0] AsyncIn,
    output logic [CHANNELS-1:0] Level,
    output logic [CHANNELS-1:0] RisingEdge,
    output logic [CHANNELS-1:0] FallingEdge,
    output logic [CHANNELS-1:0] Timeout
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        multi_edge_detect_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .FILTER_LEN     (FILTER_LEN),
            .RESET_LEVEL    (RESET_LEVEL),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_chan (
            .clk          (Clock),
            .rst_n        (Reset_n),
            .async_in     (AsyncIn[i]),
            .level        (Level[i]),
            .rising_edge  (RisingEdge[i]),
            .falling_edge (FallingEdge[i]),
            .timeout      (Timeout[i])
        );
    end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed self-checking bench for multi_edge_detect: a default 2-channel instance
// (TIMEOUT_CYCLES=100) and a 4-channel FILTER_LEN=1 instance driven by square waves.
module tb_multi_edge_detect;

`ifdef MULTI_EDGE_DETECT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       Clock;
    logic       Reset_n;
    logic [1:0] AsyncIn;
    logic [1:0] Level;
    logic [1:0] RisingEdge;
    logic [1:0] FallingEdge;
    logic [1:0] Timeout;

    logic [3:0] asyncIn4;
    logic [3:0] level4;
    logic [3:0] rise4;
    logic [3:0] fall4;
    logic [3:0] timeout4;

    int checks   = 0;
    int failures = 0;
    int riseCnt[2];
    int fallCnt[2];

    multi_edge_detect #(
        .CHANNELS       (2),
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .RESET_LEVEL    (1'b1),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .AsyncIn     (AsyncIn),
        .Level       (Level),
        .RisingEdge  (RisingEdge),
        .FallingEdge (FallingEdge),
        .Timeout     (Timeout)
    );

    multi_edge_detect #(
        .CHANNELS       (4),
        .SYNC_STAGES    (2),
        .FILTER_LEN     (1),
        .RESET_LEVEL    (1'b1),
        .TIMEOUT_CYCLES (100)
    ) dutF1 (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .AsyncIn     (asyncIn4),
        .Level       (level4),
        .RisingEdge  (rise4),
        .FallingEdge (fall4),
        .Timeout     (timeout4)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] value);
        AsyncIn = value;
    endtask

    // One rising edge, then settle 1 time unit so outputs are sampled off the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 2; i++) begin
            riseCnt[i] = 0;
            fallCnt[i] = 0;
        end
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                riseCnt[i] += int'(RisingEdge[i]);
                fallCnt[i] += int'(FallingEdge[i]);
            end
        end
    endtask

    task automatic glitch(input int width);
        clearCounts();
        applyStimulus(2'b10);
        runCycles(width);
        applyStimulus(2'b11);
        runCycles(12);
    endtask

    // Square wave, period 16, channel ch offset by 2*ch cycles; starts high.
    function automatic logic waveBit(input int n, input int ch);
        int p;
        p = n + 2 * ch;
        return ((p / 8) % 2) == 0;
    endfunction

    // FILTER_LEN=1: level after edge m equals the value applied before edge m-2.
    function automatic logic [3:0] expLevel4(input int m);
        logic [3:0] v;
        for (int ch = 0; ch < 4; ch++) begin
            v[ch] = (m < 3) ? 1'b1 : waveBit(m - 3, ch);
        end
        return v;
    endfunction

    initial begin
        Reset_n  = 1'b1;
        AsyncIn  = 2'b11;
        asyncIn4 = 4'hF;
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("reset_level", 32'(Level), 32'(2'b11));
        checkOutput("reset_rise", 32'(RisingEdge), 32'(2'b00));
        checkOutput("reset_fall", 32'(FallingEdge), 32'(2'b00));
        checkOutput("reset_timeout", 32'(Timeout), 32'(2'b00));
        tick();
        tick();
        Reset_n = 1'b1;

        // Idle after reset: no strobes, Level held, timeout exactly at edge 100
        clearCounts();
        runCycles(99);
        checkOutput("idle_timeout_99", 32'(Timeout), 32'(2'b00));
        runCycles(1);
        checkOutput("idle_timeout_100", 32'(Timeout), TO_EN ? 32'(2'b11) : 32'(2'b00));
        checkOutput("idle_no_rise", 32'(riseCnt[0] + riseCnt[1]), 32'd0);
        checkOutput("idle_no_fall", 32'(fallCnt[0] + fallCnt[1]), 32'd0);
        checkOutput("idle_level", 32'(Level), 32'(2'b11));

        // Clean fall on channel 0: strobe at edge 6
        applyStimulus(2'b10);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("fall_e5_strobe", 32'(FallingEdge), 32'(2'b00));
        checkOutput("fall_e5_level", 32'(Level), 32'(2'b11));
        checkOutput("fall_e5_timeout", 32'(Timeout), TO_EN ? 32'(2'b11) : 32'(2'b00));
        tick();
        checkOutput("fall_e6_strobe", 32'(FallingEdge), 32'(2'b01));
        checkOutput("fall_e6_rise", 32'(RisingEdge), 32'(2'b00));
        checkOutput("fall_e6_level", 32'(Level), 32'(2'b10));
        checkOutput("fall_e6_timeout", 32'(Timeout), TO_EN ? 32'(2'b10) : 32'(2'b00));
        tick();
        checkOutput("fall_e7_strobe", 32'(FallingEdge), 32'(2'b00));
        checkOutput("fall_e7_level", 32'(Level), 32'(2'b10));

        applyStimulus(2'b11);
        runCycles(12);
        checkOutput("restore_level", 32'(Level), 32'(2'b11));

        // Glitch rejection and the shortest accepted pulse
        glitch(3);
        checkOutput("glitch3_fall", 32'(fallCnt[0]), 32'd0);
        checkOutput("glitch3_rise", 32'(riseCnt[0]), 32'd0);
        checkOutput("glitch3_level", 32'(Level), 32'(2'b11));
        glitch(4);
        checkOutput("glitch4_fall", 32'(fallCnt[0]), 32'd1);
        checkOutput("glitch4_rise", 32'(riseCnt[0]), 32'd1);
        checkOutput("glitch4_ch1", 32'(riseCnt[1] + fallCnt[1]), 32'd0);
        checkOutput("glitch4_level", 32'(Level), 32'(2'b11));

        // Simultaneous rise on both channels
        applyStimulus(2'b00);
        runCycles(12);
        checkOutput("both_low_level", 32'(Level), 32'(2'b00));
        applyStimulus(2'b11);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("both_rise_e5", 32'(RisingEdge), 32'(2'b00));
        tick();
        checkOutput("both_rise_e6", 32'(RisingEdge), 32'(2'b11));
        checkOutput("both_rise_e6_fall", 32'(FallingEdge), 32'(2'b00));
        tick();
        checkOutput("both_rise_e7", 32'(RisingEdge), 32'(2'b00));

        // Opposite-direction changes in the same cycle
        applyStimulus(2'b01);
        runCycles(12);
        checkOutput("opp_setup_level", 32'(Level), 32'(2'b01));
        applyStimulus(2'b10);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("opp_e5", 32'({RisingEdge, FallingEdge}), 32'(4'b0000));
        tick();
        checkOutput("opp_e6_rise", 32'(RisingEdge), 32'(2'b10));
        checkOutput("opp_e6_fall", 32'(FallingEdge), 32'(2'b01));
        checkOutput("opp_e6_level", 32'(Level), 32'(2'b10));

        // Reset mid-count, asserted between clock edges
        applyStimulus(2'b01);
        tick();
        tick();
        tick();
        #1;
        Reset_n = 1'b0;
        #1;
        checkOutput("midreset_level", 32'(Level), 32'(2'b11));
        checkOutput("midreset_strobes", 32'({RisingEdge, FallingEdge}), 32'(4'b0000));
        checkOutput("midreset_timeout", 32'(Timeout), 32'(2'b00));
        applyStimulus(2'b10);
        tick();
        tick();
        Reset_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        checkOutput("postreset_e5_fall", 32'(FallingEdge), 32'(2'b00));
        checkOutput("postreset_e5_level", 32'(Level), 32'(2'b11));
        tick();
        checkOutput("postreset_e6_fall", 32'(FallingEdge), 32'(2'b01));
        checkOutput("postreset_e6_level", 32'(Level), 32'(2'b10));

        // FILTER_LEN=1 square waves on four channels
        Reset_n = 1'b0;
        applyStimulus(2'b11);
        asyncIn4 = 4'hF;
        tick();
        tick();
        Reset_n = 1'b1;
        for (int n = 0; n < 64; n++) begin
            logic [3:0] cur;
            logic [3:0] prev;
            for (int ch = 0; ch < 4; ch++) asyncIn4[ch] = waveBit(n, ch);
            tick();
            cur  = expLevel4(n + 1);
            prev = expLevel4(n);
            checkOutput($sformatf("sq_level_e%0d", n + 1), 32'(level4), 32'(cur));
            checkOutput($sformatf("sq_rise_e%0d", n + 1), 32'(rise4), 32'(cur & ~prev));
            checkOutput($sformatf("sq_fall_e%0d", n + 1), 32'(fall4), 32'(~cur & prev));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
